// File: rtl/comparator_sar_search.sv
// Successive-approximation search that drives a probe into a comparator and narrows [lo,hi] until equal.
// Optional COMPARATOR_SETTLE_EN inserts a one-cycle SETTLE state after every probe update.
module comparator_sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             equal,
  input  logic             less_than,
  input  logic             greater_than,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  localparam int IW = $clog2(WIDTH + 3);
  localparam logic [IW-1:0]    ITER_MAX = IW'(WIDTH + 1);
  localparam logic [IW-1:0]    ITER_ONE = IW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1
`ifdef COMPARATOR_SETTLE_EN
    ,S_SETTLE = 2'd2
`endif
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] lo, hi, lo_n, hi_n, nlo, nhi;
  logic [WIDTH-1:0] probe_n, result_n;
  logic [IW-1:0]    iter, iter_n;
  logic             busy_n, done_n, found_n, error_n;
  logic             upd, fin;
  logic [WIDTH:0]   mid_w;
  logic [2:0]       flags;

  assign dbg_state = state;
  assign flags     = {equal, less_than, greater_than};

  // Handshake: start is taken only in IDLE and not while done is high; busy rises the
  // cycle after an accepted start and falls together with the single-cycle done pulse.
  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    probe_n  = probe;
    iter_n   = iter;
    result_n = result;
    busy_n   = busy;
    done_n   = 1'b0;
    found_n  = found;
    error_n  = error;
    nlo      = lo;
    nhi      = hi;
    upd      = 1'b0;
    fin      = 1'b0;
    mid_w    = '0;
    case (state)
      S_IDLE: begin
        if (start && !done) begin
          nlo      = '0;
          nhi      = '1;
          upd      = 1'b1;
          iter_n   = ITER_ONE;
          busy_n   = 1'b1;
          found_n  = 1'b0;
          error_n  = 1'b0;
          result_n = '0;
        end
      end
      S_EVAL: begin
        case (flags)
          3'b100: begin
            result_n = probe;
            found_n  = 1'b1;
            fin      = 1'b1;
          end
          3'b010: begin
            // Bound check before probe-1 so the range never wraps below lo.
            if (probe == lo || iter == ITER_MAX) begin
              error_n = 1'b1;
              fin     = 1'b1;
            end else begin
              nhi    = probe - ONE;
              upd    = 1'b1;
              iter_n = iter + ITER_ONE;
            end
          end
          3'b001: begin
            if (probe == hi || iter == ITER_MAX) begin
              error_n = 1'b1;
              fin     = 1'b1;
            end else begin
              nlo    = probe + ONE;
              upd    = 1'b1;
              iter_n = iter + ITER_ONE;
            end
          end
          default: begin
            error_n = 1'b1;
            fin     = 1'b1;
          end
        endcase
      end
`ifdef COMPARATOR_SETTLE_EN
      S_SETTLE: state_n = S_EVAL;
`endif
      default: state_n = S_IDLE;
    endcase

    // Midpoint at WIDTH+1 bits so hi=max cannot overflow.
    mid_w = {1'b0, nlo} + (({1'b0, nhi} - {1'b0, nlo}) >> 1);

    if (fin) begin
      done_n  = 1'b1;
      busy_n  = 1'b0;
      state_n = S_IDLE;
    end
    if (upd) begin
      lo_n    = nlo;
      hi_n    = nhi;
      probe_n = mid_w[WIDTH-1:0];
`ifdef COMPARATOR_SETTLE_EN
      state_n = S_SETTLE;
`else
      state_n = S_EVAL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      iter   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      probe  <= probe_n;
      iter   <= iter_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
      found  <= found_n;
      error  <= error_n;
    end
  end

endmodule

// File: tb/tb_comparator_sar_search.sv
// Directed bench for comparator_sar_search with a behavioural comparator on input_a = target.
// Latency expectations scale by two when COMPARATOR_SETTLE_EN is defined.
module tb_comparator_sar_search;

`ifdef COMPARATOR_SETTLE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] probe, result;
  logic       equal, less_than, greater_than;
  logic       busy, done, found, error;
  logic [1:0] dbg_state;

  logic [3:0] target;
  logic       force_en;
  logic [2:0] force_flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] seen[$];
  logic [3:0] exp_q[$];
  int cycles;

  always #5 clk = ~clk;

  comparator_sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe),
    .equal(equal), .less_than(less_than), .greater_than(greater_than),
    .busy(busy), .done(done), .found(found), .error(error),
    .result(result), .dbg_state(dbg_state)
  );

  // Behavioural comparator, optionally overridden with forced flags.
  always_comb begin
    if (force_en) begin
      {equal, less_than, greater_than} = force_flags;
    end else begin
      equal        = (target == probe);
      less_than    = (target < probe);
      greater_than = (target > probe);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulses start, records distinct probes and counts cycles from the start edge to done.
  task automatic run_search(input logic [3:0] t);
    tick;
    target = t;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    seen.delete();
    seen.push_back(probe);
    cycles = 0;
    while (!done && cycles < 40) begin
      tick;
      cycles++;
      if (!done && probe != seen[$]) seen.push_back(probe);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL search_timeout target=%0d: done not seen after %0d cycles", t, cycles);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; target = 4'd0; force_en = 1'b0; force_flags = 3'b000;
    tick; tick;
    checks++; if (probe !== 4'd0)  begin errors++; $display("FAIL reset_probe got=%0d exp=0", probe); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if ({busy, done, found, error} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, found, error}); end
    rst = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single;
    run_search(4'd5);
    exp_q = '{4'd7, 4'd3, 4'd5};
    checks++; if (seen.size() != exp_q.size())
      begin errors++; $display("FAIL t5_nprobes got=%0d exp=%0d", seen.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
      checks++; if (seen[i] !== exp_q[i])
        begin errors++; $display("FAIL t5_probe[%0d] got=%0d exp=%0d", i, seen[i], exp_q[i]); end
    end
    checks++; if (cycles != 3 * LAT) begin errors++; $display("FAIL t5_latency got=%0d exp=%0d", cycles, 3 * LAT); end
    checks++; if ({found, error, busy} !== 3'b100)
      begin errors++; $display("FAIL t5_status got=%b exp=100", {found, error, busy}); end
    checks++; if (result !== 4'd5) begin errors++; $display("FAIL t5_result got=%0d exp=5", result); end
    tick; tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t5_done_pulse got=%b exp=0", done); end
    checks++; if ({found, result, probe} !== {1'b1, 4'd5, 4'd5})
      begin errors++; $display("FAIL t5_hold got=%b/%0d/%0d exp=1/5/5", found, result, probe); end
  endtask

  task automatic test_edges;
    run_search(4'd0);
    exp_q = '{4'd7, 4'd3, 4'd1, 4'd0};
    checks++; if (seen.size() != exp_q.size())
      begin errors++; $display("FAIL t0_nprobes got=%0d exp=%0d", seen.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
      checks++; if (seen[i] !== exp_q[i])
        begin errors++; $display("FAIL t0_probe[%0d] got=%0d exp=%0d", i, seen[i], exp_q[i]); end
    end
    checks++; if ({found, error, result} !== {2'b10, 4'd0} || cycles != 4 * LAT)
      begin errors++; $display("FAIL t0_result got=%b%b/%0d lat=%0d exp=10/0 lat=%0d", found, error, result, cycles, 4 * LAT); end

    run_search(4'd15);
    exp_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
    checks++; if (seen.size() != exp_q.size())
      begin errors++; $display("FAIL t15_nprobes got=%0d exp=%0d", seen.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
      checks++; if (seen[i] !== exp_q[i])
        begin errors++; $display("FAIL t15_probe[%0d] got=%0d exp=%0d", i, seen[i], exp_q[i]); end
    end
    checks++; if ({found, error, result} !== {2'b10, 4'd15} || cycles != 5 * LAT)
      begin errors++; $display("FAIL t15_result got=%b%b/%0d lat=%0d exp=10/15 lat=%0d", found, error, result, cycles, 5 * LAT); end
  endtask

  task automatic test_flag_errors;
    logic [2:0] pats[2];
    pats[0] = 3'b000;
    pats[1] = 3'b110;
    for (int p = 0; p < 2; p++) begin
      tick;
      target = 4'd9;
      start  = 1'b1;
      tick;
      start = 1'b0;
      force_en = 1'b1;
      force_flags = pats[p];
      cycles = 0;
      while (!done && cycles < 20) begin tick; cycles++; end
      checks++; if (cycles != LAT)
        begin errors++; $display("FAIL flags%b_latency got=%0d exp=%0d", pats[p], cycles, LAT); end
      checks++; if ({done, error, found, busy} !== 4'b1100)
        begin errors++; $display("FAIL flags%b_status got=%b exp=1100", pats[p], {done, error, found, busy}); end
      checks++; if (result !== 4'd0)
        begin errors++; $display("FAIL flags%b_result got=%0d exp=0", pats[p], result); end
      force_en = 1'b0;
    end
  endtask

  task automatic test_bounds;
    force_en = 1'b1;
    force_flags = 3'b010;
    run_search(4'd0);
    checks++; if (seen.size() != 4 || seen[$] !== 4'd0 || cycles != 4 * LAT)
      begin errors++; $display("FAIL lo_bound got n=%0d last=%0d lat=%0d exp n=4 last=0 lat=%0d", seen.size(), seen[$], cycles, 4 * LAT); end
    checks++; if ({error, found, result} !== {2'b10, 4'd0})
      begin errors++; $display("FAIL lo_bound_status got=%b%b/%0d exp=10/0", error, found, result); end
    force_flags = 3'b001;
    run_search(4'd0);
    checks++; if (seen.size() != 5 || seen[$] !== 4'd15 || cycles != 5 * LAT)
      begin errors++; $display("FAIL hi_bound got n=%0d last=%0d lat=%0d exp n=5 last=15 lat=%0d", seen.size(), seen[$], cycles, 5 * LAT); end
    checks++; if ({error, found, result} !== {2'b10, 4'd0})
      begin errors++; $display("FAIL hi_bound_status got=%b%b/%0d exp=10/0", error, found, result); end
    force_en = 1'b0;
  endtask

  task automatic test_start_ignored_and_reset;
    logic any_done;
    tick;
    target = 4'd5;
    start  = 1'b1;
    tick;
    for (int i = 0; i < LAT; i++) tick;
    checks++; if ({probe, busy} !== {4'd3, 1'b1})
      begin errors++; $display("FAIL restart_ignored got probe=%0d busy=%b exp probe=3 busy=1", probe, busy); end
    start = 1'b0;
    rst   = 1'b1;
    tick;
    checks++; if ({probe, result, busy, done, found, error} !== 12'd0)
      begin errors++; $display("FAIL midreset got=%h exp=000", {probe, result, busy, done, found, error}); end
    rst = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 8; i++) begin tick; any_done |= done | busy; end
    checks++; if (any_done !== 1'b0)
      begin errors++; $display("FAIL midreset_quiet got=%b exp=0", any_done); end
  endtask

  task automatic test_start_on_done;
    run_search(4'd6);
    start = 1'b1;
    tick;
    checks++; if ({busy, found, result} !== {2'b01, 4'd6})
      begin errors++; $display("FAIL start_on_done got busy=%b found=%b result=%0d exp 0/1/6", busy, found, result); end
    tick;
    start = 1'b0;
    checks++; if ({busy, found, probe} !== {2'b10, 4'd7})
      begin errors++; $display("FAIL start_after_done got busy=%b found=%b probe=%0d exp 1/0/7", busy, found, probe); end
    cycles = 0;
    while (!done && cycles < 20) begin tick; cycles++; end
    checks++; if ({done, found, result} !== {2'b11, 4'd6})
      begin errors++; $display("FAIL start_after_done_result got=%b%b/%0d exp=11/6", done, found, result); end
  endtask

  task automatic test_sweep;
    for (int t = 0; t < 16; t++) begin
      run_search(4'(t));
      checks++; if ({found, error} !== 2'b10 || result !== 4'(t) || seen[$] !== 4'(t))
        begin errors++; $display("FAIL sweep%0d got found=%b error=%b result=%0d exp 1/0/%0d", t, found, error, result, t); end
      checks++; if (seen.size() > 5 || cycles != seen.size() * LAT)
        begin errors++; $display("FAIL sweep%0d_latency got n=%0d lat=%0d exp n<=5 lat=%0d", t, seen.size(), cycles, seen.size() * LAT); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_edges;
    test_flag_errors;
    test_bounds;
    test_start_ignored_and_reset;
    test_start_on_done;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
